// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Definitions shared by the LFSR step controller and its shift-register core:
// the debounce FSM state type, the LFSR reset value and tap mask, and the
// feedback helper.
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // The LFSR never holds all zeros, so both reset and a zero seed land here.
    localparam logic [7:0] LFSR_RESET    = 8'h01;

    // Taps at bits 4, 3, 2 and 0.
    localparam logic [7:0] LFSR_TAP_MASK = 8'h1D;

    // Feedback bit is the XOR of the tapped state bits.
    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// lfsr_step_ctrl_if
// Groups the control and status signals of lfsr_step_ctrl.
//   btn_raw     : raw asynchronous push-button
//   mode        : 0 = manual (button steps), 1 = auto (timed steps)
//   period_sel  : auto period select (x1, x2, x4, x8)
//   load        : single-cycle seed load strobe
//   seed        : value loaded on load
//   step_pulse  : one-cycle pulse marking an accepted step
//   lfsr_out    : current LFSR state
//   step_cnt    : accepted-step counter, wraps at 16 bits
// master drives the controls, slave (the controller) drives the status.
// -----------------------------------------------------------------------------
interface lfsr_step_ctrl_if;

    logic        btn_raw;
    logic        mode;
    logic [1:0]  period_sel;
    logic        load;
    logic [7:0]  seed;
    logic        step_pulse;
    logic [7:0]  lfsr_out;
    logic [15:0] step_cnt;

    modport master (
        output btn_raw, mode, period_sel, load, seed,
        input  step_pulse, lfsr_out, step_cnt
    );

    modport slave (
        input  btn_raw, mode, period_sel, load, seed,
        output step_pulse, lfsr_out, step_cnt
    );

endinterface

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit right-shifting Fibonacci LFSR with synchronous seed load.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, state returns to LFSR_RESET
//   step : advance one position this edge
//   load : load seed this edge (takes priority over step)
//   seed : load value; zero is replaced by LFSR_RESET to avoid lockup
//   q    : current state
// -----------------------------------------------------------------------------
module lfsr8
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       load,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic [7:0] w_load_val;

    // An all-zero state would never leave zero, so a zero seed is remapped.
    assign w_load_val = (seed == 8'h00) ? LFSR_RESET : seed;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_RESET;
        end else if (load) begin
            r_q <= w_load_val;
        end else if (step) begin
            r_q <= {lfsr_feedback(r_q), r_q[7:1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_step_ctrl
// Steps an 8-bit LFSR either from a debounced push-button (manual mode) or
// from a programmable prescaler (auto mode), and counts accepted steps.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : lfsr_step_ctrl_if.slave (btn_raw, mode, period_sel, load, seed in;
//          step_pulse, lfsr_out, step_cnt out)
// Parameters:
//   DEB_CYCLES  : consecutive stable samples needed to accept a button edge
//   TICK_CYCLES : base auto-step period in clk cycles
// -----------------------------------------------------------------------------
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int TICK_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_step_ctrl_if.slave     bus
);

    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PRESC_W = (TICK_CYCLES * 8 > 1) ? $clog2(TICK_CYCLES * 8) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Button synchronizer
    // ---------------------------------------------------------------------
    logic r_sync_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= bus.btn_raw;
            r_sync      <= r_sync_meta;
        end
    end

    // ---------------------------------------------------------------------
    // Debounce FSM
    // The counter counts stable samples while in a *_WAIT state; any
    // contrary sample sends the FSM back and clears it.
    // ---------------------------------------------------------------------
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEB_W-1:0] w_deb_cnt_nxt;
    logic             w_press_accept;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_deb_cnt_nxt  = '0;
        w_press_accept = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_sync) begin
                    w_state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync) begin
                    w_state_nxt = IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt    = HELD;
                    w_press_accept = 1'b1;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync) begin
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync) begin
                    w_state_nxt = HELD;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Auto-step prescaler
    // Held at zero in manual mode and for the cycle period_sel changes, so a
    // new mode or period always starts with a full period.
    // ---------------------------------------------------------------------
    logic [1:0]         r_sel_q;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_last;
    logic               w_sel_chg;
    logic               w_tick;

    assign w_presc_last = PRESC_W'((TICK_CYCLES << bus.period_sel) - 1);
    assign w_sel_chg    = (bus.period_sel != r_sel_q);
    assign w_tick       = bus.mode && !w_sel_chg && (r_presc == w_presc_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_q <= 2'd0;
            r_presc <= '0;
        end else begin
            r_sel_q <= bus.period_sel;
            if (!bus.mode || w_sel_chg || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Step pulse: press acceptance in manual mode, prescaler tick in auto.
    // Registered, so a manual step appears the cycle after entering HELD.
    // ---------------------------------------------------------------------
    logic r_step_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= bus.mode ? w_tick : w_press_accept;
        end
    end

    // ---------------------------------------------------------------------
    // Step counter: a step that collides with a load is discarded.
    // ---------------------------------------------------------------------
    logic [15:0] r_step_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= 16'h0000;
        end else if (r_step_pulse && !bus.load) begin
            r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Shift register
    // ---------------------------------------------------------------------
    logic [7:0] w_lfsr_q;

    lfsr8 u_lfsr8 (
        .clk  (clk),
        .rst  (rst),
        .step (r_step_pulse),
        .load (bus.load),
        .seed (bus.seed),
        .q    (w_lfsr_q)
    );

    assign bus.step_pulse = r_step_pulse;
    assign bus.lfsr_out   = w_lfsr_q;
    assign bus.step_cnt   = r_step_cnt;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lfsr_step_ctrl
// Directed self-checking bench for lfsr_step_ctrl (DEB_CYCLES = 4,
// TICK_CYCLES = 4). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lfsr_step_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lfsr_step_ctrl_if bus ();

    lfsr_step_ctrl #(
        .DEB_CYCLES  (4),
        .TICK_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance n cycles, ending just after a falling edge.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Advance n cycles, counting step pulses and noting the cycle index
    // (1-based) of the first and last one.
    task automatic run_cycles(input int n, output int pulses,
                              output int first_idx, output int last_idx);
        pulses    = 0;
        first_idx = 0;
        last_idx  = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.step_pulse === 1'b1) begin
                pulses++;
                if (first_idx == 0) first_idx = i;
                last_idx = i;
            end
        end
    endtask

    task automatic test_reset;
        int p, f, l;
        checks++;
        if (bus.lfsr_out !== 8'h01) begin
            errors++;
            $display("FAIL reset_lfsr: got %h expected 01", bus.lfsr_out);
        end
        checks++;
        if (bus.step_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt: got %h expected 0000", bus.step_cnt);
        end
        checks++;
        if (bus.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse: got %b expected 0", bus.step_pulse);
        end
        run_cycles(12, p, f, l);
        checks++;
        if (p != 0 || bus.lfsr_out !== 8'h01) begin
            errors++;
            $display("FAIL idle_after_reset: pulses %0d lfsr %h expected 0 / 01", p, bus.lfsr_out);
        end
    endtask

    task automatic press(input int hold, input int gap, output int pulses);
        int p1, p2, f, l;
        bus.btn_raw = 1'b1;
        run_cycles(hold, p1, f, l);
        bus.btn_raw = 1'b0;
        run_cycles(gap, p2, f, l);
        pulses = p1 + p2;
    endtask

    task automatic test_manual_press;
        int p;
        press(20, 12, p);
        checks++;
        if (p != 1 || bus.lfsr_out !== 8'h80) begin
            errors++;
            $display("FAIL press1: pulses %0d lfsr %h expected 1 / 80", p, bus.lfsr_out);
        end
        press(20, 12, p);
        checks++;
        if (p != 1 || bus.lfsr_out !== 8'h40) begin
            errors++;
            $display("FAIL press2: pulses %0d lfsr %h expected 1 / 40", p, bus.lfsr_out);
        end
        checks++;
        if (bus.step_cnt !== 16'd2) begin
            errors++;
            $display("FAIL press_cnt: got %0d expected 2", bus.step_cnt);
        end
    endtask

    task automatic test_short_pulses;
        int p, total;
        total = 0;
        for (int w = 1; w <= 3; w++) begin
            press(w, 10, p);
            total += p;
        end
        checks++;
        if (total != 0 || bus.lfsr_out !== 8'h40 || bus.step_cnt !== 16'd2) begin
            errors++;
            $display("FAIL short_pulses: pulses %0d lfsr %h cnt %0d expected 0 / 40 / 2",
                     total, bus.lfsr_out, bus.step_cnt);
        end
    endtask

    task automatic test_load_zero;
        bus.seed = 8'h00;
        bus.load = 1'b1;
        tick_n(1);
        bus.load = 1'b0;
        checks++;
        if (bus.lfsr_out !== 8'h01 || bus.step_cnt !== 16'd2) begin
            errors++;
            $display("FAIL load_zero: lfsr %h cnt %0d expected 01 / 2", bus.lfsr_out, bus.step_cnt);
        end
    endtask

    task automatic test_auto;
        logic [7:0] exp_after [3];
        int idx [3];
        int n;
        exp_after = '{8'h80, 8'h40, 8'h20};
        n = 0;
        bus.mode = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.step_pulse === 1'b1) begin
                if (n < 3) idx[n] = i;
                n++;
            end
            if (i == 5 || i == 9 || i == 13) begin
                checks++;
                if (bus.lfsr_out !== exp_after[(i - 5) / 4]) begin
                    errors++;
                    $display("FAIL auto_seq_c%0d: got %h expected %h", i, bus.lfsr_out,
                             exp_after[(i - 5) / 4]);
                end
            end
        end
        bus.mode = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL auto_count: got %0d expected 3", n);
        end else begin
            checks++;
            if (idx[0] != 4 || idx[1] != 8 || idx[2] != 12) begin
                errors++;
                $display("FAIL auto_spacing: at %0d %0d %0d expected 4 8 12", idx[0], idx[1], idx[2]);
            end
        end
        tick_n(1);
        checks++;
        if (bus.step_cnt !== 16'd5) begin
            errors++;
            $display("FAIL auto_cnt: got %0d expected 5", bus.step_cnt);
        end
    endtask

    task automatic test_load_vs_step;
        bit seen;
        seen = 1'b0;
        bus.mode = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.step_pulse === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL collide_wait: no step_pulse within 20 cycles, expected one");
            bus.mode = 1'b0;
        end else begin
            bus.seed = 8'hA5;
            bus.load = 1'b1;
            bus.mode = 1'b0;
            tick_n(1);
            bus.load = 1'b0;
            checks++;
            if (bus.lfsr_out !== 8'hA5 || bus.step_cnt !== 16'd5) begin
                errors++;
                $display("FAIL collide: lfsr %h cnt %0d expected A5 / 5", bus.lfsr_out, bus.step_cnt);
            end
        end
    endtask

    task automatic test_period_sel;
        int p, f, l;
        bus.period_sel = 2'd1;
        tick_n(1);
        bus.mode = 1'b1;
        run_cycles(17, p, f, l);
        bus.mode = 1'b0;
        checks++;
        if (p != 2 || f != 8 || l != 16) begin
            errors++;
            $display("FAIL sel1_timing: pulses %0d at %0d..%0d expected 2 at 8..16", p, f, l);
        end
        checks++;
        if (bus.lfsr_out !== 8'hA9 || bus.step_cnt !== 16'd7) begin
            errors++;
            $display("FAIL sel1_state: lfsr %h cnt %0d expected A9 / 7", bus.lfsr_out, bus.step_cnt);
        end
        bus.period_sel = 2'd0;
        tick_n(1);
    endtask

    task automatic test_mode_change_held;
        int p1, p2, p3, f, l;
        bus.period_sel = 2'd3;
        bus.mode       = 1'b1;
        bus.btn_raw    = 1'b1;
        run_cycles(10, p1, f, l);
        bus.mode = 1'b0;
        run_cycles(10, p2, f, l);
        bus.btn_raw = 1'b0;
        run_cycles(12, p3, f, l);
        checks++;
        if (p1 + p2 + p3 != 0 || bus.lfsr_out !== 8'hA9 || bus.step_cnt !== 16'd7) begin
            errors++;
            $display("FAIL mode_in_held: pulses %0d lfsr %h cnt %0d expected 0 / A9 / 7",
                     p1 + p2 + p3, bus.lfsr_out, bus.step_cnt);
        end
        bus.period_sel = 2'd0;
        tick_n(1);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.lfsr_out !== 8'h01 || bus.step_cnt !== 16'h0000 || bus.step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s: lfsr %h cnt %h pulse %b expected 01 / 0000 / 0",
                     name, bus.lfsr_out, bus.step_cnt, bus.step_pulse);
        end
    endtask

    task automatic test_reset_mid_press;
        int p, f, l;
        bus.btn_raw = 1'b1;
        tick_n(4);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_press");
        bus.btn_raw = 1'b0;
        tick_n(2);
        rst = 1'b0;
        run_cycles(12, p, f, l);
        checks++;
        if (p != 0 || bus.lfsr_out !== 8'h01) begin
            errors++;
            $display("FAIL after_rst_press: pulses %0d lfsr %h expected 0 / 01", p, bus.lfsr_out);
        end
    endtask

    task automatic test_reset_mid_period;
        int p, f, l;
        bus.mode = 1'b1;
        run_cycles(6, p, f, l);
        checks++;
        if (p != 1 || bus.lfsr_out !== 8'h80) begin
            errors++;
            $display("FAIL pre_rst_auto: pulses %0d lfsr %h expected 1 / 80", p, bus.lfsr_out);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_period");
        bus.mode = 1'b0;
        tick_n(2);
        rst = 1'b0;
        run_cycles(12, p, f, l);
        checks++;
        if (p != 0) begin
            errors++;
            $display("FAIL after_rst_period: pulses %0d expected 0", p);
        end
        check_reset_outputs("idle_after_rst_period");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_raw    = 1'b0;
        bus.mode       = 1'b0;
        bus.period_sel = 2'd0;
        bus.load       = 1'b0;
        bus.seed       = 8'h00;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_manual_press();
        test_short_pulses();
        test_load_zero();
        test_auto();
        test_load_vs_step();
        test_period_sel();
        test_mode_change_held();
        test_reset_mid_press();
        test_reset_mid_period();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_step_ctrl.md
LFSR_STEP_CTRL -- requirements
Module: lfsr_step_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable synchronized samples required to accept a button edge.
REQ-002 SHALL have parameter TICK_CYCLES, default 4: base auto-step period in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_raw  input  1  raw, bouncy, asynchronous push-button.
REQ-006 SHALL have port mode  input  1  0 = manual (button steps), 1 = auto (timed steps).
REQ-007 SHALL have port period_sel  input  2  auto period select.
REQ-008 SHALL have port load  input  1  single-cycle seed load strobe.
REQ-009 SHALL have port seed  input  8  value loaded on load.
REQ-010 SHALL have port step_pulse  output  1  one-cycle pulse marking an accepted step.
REQ-011 SHALL have port lfsr_out  output  8  current LFSR state.
REQ-012 SHALL have port step_cnt  output  16  accepted-step counter, wraps 0xFFFF -> 0x0000.

Function
REQ-013 SHALL pass btn_raw through a two-flop synchronizer before any use; sync flops reset to 0.
REQ-014 SHALL implement debounce FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE -> PRESS_WAIT on synced button = 1; PRESS_WAIT -> HELD after DEB_CYCLES consecutive 1 samples; PRESS_WAIT -> IDLE on any 0 sample, debounce counter cleared.
REQ-016 HELD -> RELEASE_WAIT on synced 0; RELEASE_WAIT -> IDLE after DEB_CYCLES consecutive 0 samples; RELEASE_WAIT -> HELD on any 1 sample.
REQ-017 In manual mode, step_pulse SHALL assert for exactly one cycle, the cycle after the PRESS_WAIT -> HELD transition; one step per press regardless of hold length.
REQ-018 In auto mode, a prescaler SHALL assert step_pulse once every TICK_CYCLES << period_sel cycles (sel 0..3 -> x1, x2, x4, x8); button presses are ignored for stepping.
REQ-019 The prescaler SHALL clear to 0 while mode = 0 and on any change of period_sel; first auto step comes a full period after mode rises.
REQ-020 On the clock edge ending a cycle with step_pulse = 1, lfsr_out SHALL become {fb, lfsr_out[7:1]}, fb = lfsr_out[4]^lfsr_out[3]^lfsr_out[2]^lfsr_out[0], and step_cnt SHALL increment by 1.
REQ-021 load = 1 SHALL set lfsr_out to seed on the next edge; seed = 0x00 SHALL load 0x01 (all-zero lockup forbidden); step_cnt unaffected.
REQ-022 load and step_pulse in the same cycle: load wins, step discarded, step_cnt not incremented.
REQ-023 Mode change while the FSM is in HELD SHALL NOT generate a step; the FSM keeps tracking the button in both modes.

Reset
REQ-024 On rst: lfsr_out = 0x01, step_cnt = 0x0000, step_pulse = 0, FSM = IDLE, debounce counter and prescaler = 0, sync flops = 0.
REQ-025 rst asserted mid-debounce or mid-period SHALL abort immediately; no step is produced on release of rst.

Structure
REQ-026 SHALL place FSM state enum, LFSR reset value 0x01 and tap mask 0x1D in shared package lfsr_pkg.
REQ-027 SHALL instantiate one sub-module lfsr8 (clk, rst, step, load, seed, q) containing the shift register and feedback.
REQ-028 Debounce FSM, prescaler and step counter SHALL reside in lfsr_step_ctrl.

Verification
REQ-029 Reset release, no input -> lfsr_out = 0x01, step_cnt = 0, step_pulse never asserts.
REQ-030 Manual: clean press held 20 cycles then released -> exactly one step_pulse; lfsr_out 0x01 -> 0x80; second press -> 0x40; step_cnt = 2.
REQ-031 Manual: btn_raw pulses of 1-3 cycles (shorter than DEB_CYCLES = 4) -> no step_pulse, lfsr_out unchanged.
REQ-032 Auto, period_sel = 0, TICK_CYCLES = 4: 12 cycles after mode rises -> 3 pulses, spaced 4 cycles apart; lfsr_out sequence 0x80, 0x40, 0x20.
REQ-033 load with seed = 0x00 -> lfsr_out = 0x01; load with seed = 0xA5 in the same cycle as an auto step -> lfsr_out = 0xA5, step_cnt unchanged.
REQ-034 rst pulse during PRESS_WAIT and during an auto period -> outputs return to reset values, no spurious step_pulse after rst deasserts.
